// File: rtl/rs_integer_station.sv
// Integer reservation station: buffers dispatched ops, wakes operands from the CDB, issues one ready op per cycle.
// Optional macro RS_AGE_ORDER_EN selects the oldest ready entry (age matrix) instead of the lowest index.
module rs_integer_station #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dp_valid,
  input  logic [75:0]                  dp_packet,
  output logic                         is_full,
  input  logic                         flush,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic [31:0]                  cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [73:0]                  issue_packet,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] busy_q, busy_d, v1_q, v1_d, v2_q, v2_d;
  logic [3:0]       op_q   [DEPTH];
  logic [3:0]       op_d   [DEPTH];
  logic [TAG_W-1:0] dest_q [DEPTH];
  logic [TAG_W-1:0] dest_d [DEPTH];
  logic [31:0]      op1_q  [DEPTH];
  logic [31:0]      op1_d  [DEPTH];
  logic [31:0]      op2_q  [DEPTH];
  logic [31:0]      op2_d  [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;

  logic [DEPTH-1:0] ready_s;
  logic [IDX_W-1:0] sel_idx_s, free_idx_s;
  logic             sel_found_s, free_found_s;
  logic [CNT_W-1:0] busy_cnt_s;
  logic             wr_en_s, iss_fire_s;
  logic [32:0]      cap1_s, cap2_s;

`ifdef RS_AGE_ORDER_EN
  // age_q[i][j] set means entry j was already waiting when entry i was written
  logic [DEPTH-1:0] age_q [DEPTH];
  logic [DEPTH-1:0] age_d [DEPTH];
`endif

  // An invalid operand whose producer tag is on the CDB this cycle takes the broadcast value.
  function automatic logic [32:0] capture_operand(input logic v, input logic [31:0] opnd,
                                                  input logic cv, input logic [TAG_W-1:0] ct,
                                                  input logic [31:0] cd);
    if (!v && cv && (opnd[TAG_W-1:0] == ct)) begin
      capture_operand = {1'b1, cd};
    end else begin
      capture_operand = {v, opnd};
    end
  endfunction

  // Readiness, occupancy and free-slot search, all from registered state.
  always_comb begin
    ready_s      = '0;
    busy_cnt_s   = '0;
    free_idx_s   = '0;
    free_found_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_s[i] = busy_q[i] && v1_q[i] && v2_q[i];
      busy_cnt_s = busy_cnt_s + CNT_W'(busy_q[i]);
      if (!free_found_s && !busy_q[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = IDX_W'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
  end

  // Issue selection: oldest ready entry with the age matrix, lowest-index ready entry otherwise.
  always_comb begin
    sel_idx_s   = '0;
    sel_found_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_AGE_ORDER_EN
      if (!sel_found_s && ready_s[i] && ((age_q[i] & ready_s) == '0)) begin
`else
      if (!sel_found_s && ready_s[i]) begin
`endif
        sel_found_s = 1'b1;
        sel_idx_s   = IDX_W'(i);
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign is_full      = (busy_cnt_s == CNT_W'(DEPTH));
  assign issue_valid  = sel_found_s;
  assign issue_packet = {op_q[sel_idx_s], dest_q[sel_idx_s], op1_q[sel_idx_s], op2_q[sel_idx_s]};
  assign count        = count_q;
  assign wr_en_s      = dp_valid && !is_full && !flush;
  assign iss_fire_s   = sel_found_s && issue_ready && !flush;
  assign cap1_s       = capture_operand(dp_packet[65], dp_packet[64:33], cdb_valid, cdb_tag, cdb_data);
  assign cap2_s       = capture_operand(dp_packet[32], dp_packet[31:0], cdb_valid, cdb_tag, cdb_data);

  // Entry next state: wakeup, issue release, dispatch write, then flush overrides everything.
  always_comb begin
    busy_d = busy_q;
    v1_d   = v1_q;
    v2_d   = v2_q;
    op_d   = op_q;
    dest_d = dest_q;
    op1_d  = op1_q;
    op2_d  = op2_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (cdb_valid && busy_q[i] && !v1_q[i] && (op1_q[i][TAG_W-1:0] == cdb_tag)) begin
        v1_d[i]  = 1'b1;
        op1_d[i] = cdb_data;
      end else begin
        v1_d[i]  = v1_d[i];
      end
      if (cdb_valid && busy_q[i] && !v2_q[i] && (op2_q[i][TAG_W-1:0] == cdb_tag)) begin
        v2_d[i]  = 1'b1;
        op2_d[i] = cdb_data;
      end else begin
        v2_d[i]  = v2_d[i];
      end
    end
    if (iss_fire_s) begin
      busy_d[sel_idx_s] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (wr_en_s) begin
      busy_d[free_idx_s] = 1'b1;
      op_d[free_idx_s]   = dp_packet[75:72];
      dest_d[free_idx_s] = dp_packet[66+TAG_W-1:66];
      v1_d[free_idx_s]   = cap1_s[32];
      op1_d[free_idx_s]  = cap1_s[31:0];
      v2_d[free_idx_s]   = cap2_s[32];
      op2_d[free_idx_s]  = cap2_s[31:0];
    end else begin
      busy_d = busy_d;
    end
    if (flush) begin
      busy_d = '0;
    end else begin
      busy_d = busy_d;
    end
  end

  // Occupancy counter: +write -issue, held inside 0..DEPTH.
  always_comb begin
    if (flush) begin
      count_d = '0;
    end else if (wr_en_s && !iss_fire_s && (count_q != CNT_W'(DEPTH))) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_en_s && iss_fire_s && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Entry and counter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q  <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= 4'd0;
        dest_q[i] <= '0;
        op1_q[i]  <= 32'd0;
        op2_q[i]  <= 32'd0;
      end
    end else begin
      busy_q  <= busy_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      count_q <= count_d;
      op_q    <= op_d;
      dest_q  <= dest_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
    end
  end

`ifdef RS_AGE_ORDER_EN
  // Age matrix next state: freed column cleared, new row marks every entry still waiting.
  always_comb begin
    age_d = age_q;
    if (flush) begin
      for (int r = 0; r < DEPTH; r++) begin
        age_d[r] = '0;
      end
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (iss_fire_s) begin
          age_d[r][sel_idx_s] = 1'b0;
        end else begin
          age_d[r] = age_d[r];
        end
      end
      if (wr_en_s) begin
        age_d[free_idx_s] = busy_q & ~(iss_fire_s ? (DEPTH'(1) << sel_idx_s) : '0);
      end else begin
        age_d = age_d;
      end
    end
  end

  // Age matrix register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        age_q[r] <= '0;
      end
    end else begin
      age_q <= age_d;
    end
  end
`endif

endmodule

// File: tb/tb_rs_integer_station.sv
// Scoreboard bench for rs_integer_station: a slot/sequence-number reference model predicts each cycle's outputs.
module tb_rs_integer_station;

  localparam int DEPTH = 4;
`ifdef RS_AGE_ORDER_EN
  localparam bit AGE = 1'b1;
`else
  localparam bit AGE = 1'b0;
`endif

  logic        clk, reset, dp_valid, flush, cdb_valid, issue_ready;
  logic [75:0] dp_packet;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        is_full, issue_valid;
  logic [73:0] issue_packet;
  logic [2:0]  count;

  rs_integer_station #(.DEPTH(DEPTH), .TAG_W(6)) dut (
    .clk(clk), .reset(reset), .dp_valid(dp_valid), .dp_packet(dp_packet), .is_full(is_full),
    .flush(flush), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_packet(issue_packet), .count(count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit busy; logic [3:0] op; logic [5:0] dest;
    bit v1; logic [31:0] o1; bit v2; logic [31:0] o2; int seq;
  } ent_t;
  typedef struct { bit valid; logic [73:0] pkt; int cnt; bit full; } exp_t;

  ent_t m [DEPTH];
  exp_t exp_q [$];
  int   seq_ctr = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [75:0] mk_pkt(input logic [3:0] op, input logic [5:0] dest,
                                         input bit v1, input logic [31:0] o1,
                                         input bit v2, input logic [31:0] o2);
    return {op, dest, v1, o1, v2, o2};
  endfunction

  function automatic logic [31:0] rand_opnd(input bit v);
    logic [31:0] r;
    r = $urandom;
    if (!v) r[5:0] = 6'($urandom_range(0, 7));
    return r;
  endfunction

  // One clock cycle: drive inputs, record the model's prediction, then advance the model.
  task automatic step(input bit dv, input logic [75:0] pkt, input bit fl,
                      input bit cv, input logic [5:0] ct, input logic [31:0] cd, input bit ir);
    exp_t e;
    int sel, cnt, ws;
    @(negedge clk);
    reset = 1'b0; dp_valid = dv; dp_packet = pkt; flush = fl;
    cdb_valid = cv; cdb_tag = ct; cdb_data = cd; issue_ready = ir;
    #1;
    sel = -1; cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].busy) cnt++;
      if (m[i].busy && m[i].v1 && m[i].v2) begin
        if (sel < 0) sel = i;
        else if (AGE && m[i].seq < m[sel].seq) sel = i;
      end
    end
    e.valid = (sel >= 0);
    e.pkt = '0;
    if (sel >= 0) e.pkt = {m[sel].op, m[sel].dest, m[sel].o1, m[sel].o2};
    e.cnt = cnt;
    e.full = (cnt == DEPTH);
    exp_q.push_back(e);
    if (fl) begin
      for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
    end else begin
      ws = -1;
      if (dv && cnt < DEPTH)
        for (int i = DEPTH - 1; i >= 0; i--) if (!m[i].busy) ws = i;
      if (sel >= 0 && ir) m[sel].busy = 0;
      if (cv)
        for (int i = 0; i < DEPTH; i++) if (m[i].busy) begin
          if (!m[i].v1 && m[i].o1[5:0] == ct) begin m[i].v1 = 1; m[i].o1 = cd; end
          if (!m[i].v2 && m[i].o2[5:0] == ct) begin m[i].v2 = 1; m[i].o2 = cd; end
        end
      if (ws >= 0) begin
        m[ws].busy = 1; m[ws].op = pkt[75:72]; m[ws].dest = pkt[71:66];
        m[ws].v1 = pkt[65]; m[ws].o1 = pkt[64:33]; m[ws].v2 = pkt[32]; m[ws].o2 = pkt[31:0];
        if (!m[ws].v1 && cv && m[ws].o1[5:0] == ct) begin m[ws].v1 = 1; m[ws].o1 = cd; end
        if (!m[ws].v2 && cv && m[ws].o2[5:0] == ct) begin m[ws].v2 = 1; m[ws].o2 = cd; end
        m[ws].seq = seq_ctr++;
      end
    end
  endtask

  task automatic idle(input bit ir);
    step(1'b0, 76'd0, 1'b0, 1'b0, 6'd0, 32'd0, ir);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    reset = 1'b1; dp_valid = 1'b0; dp_packet = '0; flush = 1'b0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) m[i].busy = 0;
    e.valid = 0; e.pkt = '0; e.cnt = 0; e.full = 0;
    exp_q.push_back(e);
  endtask

  // Monitor: pops each cycle's prediction and compares it against what the DUT presents.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("issue_valid", 74'(issue_valid), 74'(e.valid));
        chk("count", 74'(count), 74'(e.cnt));
        chk("is_full", 74'(is_full), 74'(e.full));
        if (e.valid && issue_valid) chk("issue_packet", issue_packet, e.pkt);
      end
    end
  end

  initial begin
    logic [73:0] held;
    reset = 1'b1;
    do_reset();
    #2; chk("reset_valid", 74'(issue_valid), 74'd0);
    chk("reset_count", 74'(count), 74'd0);
    chk("reset_full", 74'(is_full), 74'd0);

    // Ready write
    step(1, mk_pkt(4'd0, 6'd5, 1, 32'd3, 1, 32'd4), 0, 0, 6'd0, 32'd0, 0);
    #2; chk("ready_not_same_cycle", 74'(issue_valid), 74'd0);
    idle(1);
    #2; chk("ready_pkt", issue_packet, {4'd0, 6'd5, 32'd3, 32'd4});
    idle(0);
    #2; chk("freed_count", 74'(count), 74'd0);

    // Tag wakeup
    step(1, mk_pkt(4'd1, 6'd7, 0, 32'd12, 1, 32'd77), 0, 0, 6'd0, 32'd0, 0);
    idle(0); idle(0);
    step(0, 76'd0, 0, 1, 6'd12, 32'hDEADBEEF, 0);
    #2; chk("wake_not_yet", 74'(issue_valid), 74'd0);
    idle(1);
    #2; chk("wake_op1", 74'(issue_packet[63:32]), 74'(32'hDEADBEEF));
    idle(0);

    // Same-cycle capture
    step(1, mk_pkt(4'd2, 6'd8, 1, 32'd1, 0, 32'd9), 0, 1, 6'd9, 32'h55, 0);
    idle(1);
    #2; chk("capture_op2", 74'(issue_packet[31:0]), 74'(32'h55));
    idle(0);

    // Full and back-pressure
    for (int k = 0; k < 4; k++)
      step(1, mk_pkt(4'(k), 6'(40 + k), 0, 32'(20 + k), 1, 32'(100 + k)), 0, 0, 6'd0, 32'd0, 0);
    step(1, mk_pkt(4'd9, 6'd9, 1, 32'd1, 1, 32'd2), 0, 0, 6'd0, 32'd0, 0);
    #2; chk("full_flag", 74'(is_full), 74'd1);
    step(0, 76'd0, 0, 1, 6'd21, 32'hCAFE0001, 0);
    #2; chk("full_count", 74'(count), 74'd4);
    held = {4'd1, 6'd41, 32'hCAFE0001, 32'd101};
    for (int k = 0; k < 3; k++) begin
      idle(0);
      #2; chk("held_pkt", issue_packet, held);
    end
    idle(1);

    // Flush with 3 busy and a dispatch in the same cycle
    step(1, mk_pkt(4'd5, 6'd50, 1, 32'd1, 1, 32'd1), 1, 0, 6'd0, 32'd0, 1);
    #2; chk("pre_flush_count", 74'(count), 74'd3);
    idle(0);
    #2; chk("flush_count", 74'(count), 74'd0);
    chk("flush_valid", 74'(issue_valid), 74'd0);

    // Age order: A lands in entry 2, B later in entry 0
    step(1, mk_pkt(4'd1, 6'd1, 1, 32'd1, 1, 32'd1), 0, 0, 6'd0, 32'd0, 0);
    step(1, mk_pkt(4'd2, 6'd2, 1, 32'd2, 1, 32'd2), 0, 0, 6'd0, 32'd0, 0);
    step(1, mk_pkt(4'd3, 6'd10, 0, 32'd30, 1, 32'd3), 0, 0, 6'd0, 32'd0, 1);
    idle(1);
    step(1, mk_pkt(4'd4, 6'd11, 1, 32'd4, 1, 32'd4), 0, 0, 6'd0, 32'd0, 0);
    step(0, 76'd0, 0, 1, 6'd30, 32'hA0A0A0A0, 0);
    idle(1);
    #2; chk("age_first_dest", 74'(issue_packet[69:64]), AGE ? 74'd10 : 74'd11);
    idle(1); idle(0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit v1, v2;
      v1 = ($urandom_range(0, 2) != 0);
      v2 = ($urandom_range(0, 2) != 0);
      step(1'($urandom_range(0, 1)),
           mk_pkt(4'($urandom), 6'($urandom), v1, rand_opnd(v1), v2, rand_opnd(v2)),
           ($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 7));
      if (n == 200) do_reset();
    end
    idle(0); idle(0);
    @(negedge clk); #3;
    chk("scoreboard_drained", 74'(exp_q.size()), 74'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rs_integer_station.md
Name: rs_integer_station

Overview:
- Integer reservation station; receiving end of the dispatch-to-RS integer packet.
- Buffers dispatched integer ops (OP, OP_IMM, LUI) and snoops the common data bus (CDB) to wake up pending operands.
- Issues one ready op per cycle to the integer ALU over a valid/ready handshake.
- Reports fullness back to dispatch so dispatch can stall.

Parameters:
- DEPTH, 4, number of entries (2..16).
- TAG_W, 6, ROB tag width; matches the dispatch rob_dest width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- dp_valid  in  1  dispatch writes an entry this cycle.
- dp_packet  in  76  {operation[75:72], rob_dest[71:66], valid1[65], operand1[64:33], valid2[32], operand2[31:0]}.
- is_full  out  1  no free entry; feeds the integer bit of dispatch rs_is_full.
- flush  in  1  synchronous clear of all entries (mispredict).
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  TAG_W  ROB tag of the result.
- cdb_data  in  32  result value.
- issue_valid  out  1  a ready entry is presented.
- issue_ready  in  1  ALU accepts.
- issue_packet  out  74  {operation[73:70], rob_dest[69:64], operand1[63:32], operand2[31:0]}.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset: all entries invalid; issue_valid=0, is_full=0, count=0. Reset mid-operation discards all contents.
- Operand encoding: if validN=0, operandN[TAG_W-1:0] holds the producer ROB tag and the upper bits are ignored.
- Each entry holds: busy, op, rob_dest, v1, op1, v2, op2.
- Write:
  - When dp_valid and !is_full, the packet goes to the lowest-index free entry.
  - dp_valid while is_full is ignored (no write, no state change).
- Same-cycle CDB and dispatch write: if an incoming operand is invalid and its tag equals cdb_tag while cdb_valid, the entry stores cdb_data with valid=1. A result is never missed.
- Wakeup: each cycle with cdb_valid, every busy entry with vN=0 and opN tag == cdb_tag sets vN=1 and opN=cdb_data. Both operands may wake in the same cycle.
- Ready: busy && v1 && v2. An entry is at earliest issuable the cycle after it is written or woken; ready is computed from registered state only.
- Issue:
  - issue_valid = any ready entry. issue_packet comes combinationally from the selected entry.
  - Default selection is the lowest-index ready entry.
  - issue_valid && issue_ready frees the entry at the clock edge.
  - The packet must stay stable while issue_valid && !issue_ready, unless a higher-priority entry becomes ready.
- Simultaneous issue and dispatch:
  - When not full, both happen.
  - When full, is_full reflects the pre-edge state: dispatch is blocked that cycle, and the freed slot is usable next cycle.
- Flush: all busy bits clear at the next edge. Same-cycle dispatch and issue are discarded. issue_valid=0 the cycle after flush.
- is_full = (count==DEPTH), combinational from registered busy bits.
- count is updated by +write −issue, saturating within 0..DEPTH.

Optional Feature:
- Macro: RS_AGE_ORDER_EN.
- Defined:
  - Keep a DEPTH×DEPTH age matrix, with the row set on write.
  - Selection is the oldest ready entry rather than the lowest index.
  - The freed entry's column is cleared on issue or flush.
- Undefined: lowest-index selection and no age storage.

Test Plan:
- Ready write: after reset, dispatch op=0000, rob_dest=5, v1=1/op1=3, v2=1/op2=4 → issue_valid=1 the next cycle, packet {0,5,3,4}; on issue_ready, entry freed and count=0.
- Tag wakeup: dispatch rob_dest=7 with v1=0, op1 tag=12; two cycles later, cdb_valid tag=12 data=0xDEADBEEF → issue_valid=1 the following cycle, operand1=0xDEADBEEF.
- Same-cycle capture: dispatch with v2=0, tag=9, while cdb_valid tag=9 data=0x55 → issue next cycle with operand2=0x55.
- Full and back-pressure: fill DEPTH=4 not-ready entries → is_full=1. A fifth dp_valid is ignored and count stays 4. With issue_ready=0 and a ready entry, the packet is held stable for 3 cycles.
- Flush: flush with 3 busy entries and dp_valid=1 → count=0, is_full=0, issue_valid=0 the next cycle.
- Age order (RS_AGE_ORDER_EN): write A into entry 2 (after freeing 0/1), then B into entry 0; both ready → A issues first. With the macro undefined, B issues first.
